alu_cmd_dispatcher: RTL
=======================

// Module: alu_cmd_dispatcher
// PURPOSE
//  Upstream feeder for the ALU execution units (arithmetic, logic, compare, shift). Buffers ALU commands in a small FIFO.
//  Decodes the 4-bit ALU function and drives in1/in2, one unit enable and a 2-bit function code for exactly one cycle.
//  Captures the selected unit's registered result on its flag and returns it through a valid/ready result port.
// PARAMETERS
//  DATA_WIDTH   16  operand and result width (unit in1/in2/out width)
//  FIFO_DEPTH   4   command FIFO entries, power of two >= 2
//  TIMEOUT      8   cycles in WAIT without the selected unit's flag before an error response is returned
// PORTS
//  clk        in   1            single clock, all state on rising edge
//  rst        in   1            asynchronous, active-high reset
//  cmd_valid  in   1            command present
//  cmd_ready  out  1            FIFO not full; transfer on cmd_valid & cmd_ready
//  cmd_fun    in   4            ALU function: [3:2] unit select, [1:0] unit function
//  cmd_a      in   DATA_WIDTH   operand A -> in1
//  cmd_b      in   DATA_WIDTH   operand B -> in2
//  unit_in1   out  DATA_WIDTH   operand A to all units
//  unit_in2   out  DATA_WIDTH   operand B to all units
//  unit_fun   out  2            function code to all units (shift: 00 SHR by 1, 01 SHL by 1)
//  unit_en    out  4            one-hot enable {shift,cmp,logic,arith}, bit i = unit i
//  unit_out   in   4*DATA_WIDTH packed unit results, slice i = unit i
//  unit_flag  in   4            unit result-valid flags, bit i = unit i
//  res_valid  out  1            result held for consumer
//  res_ready  in   1            consumer accepts; transfer on res_valid & res_ready
//  res_data   out  DATA_WIDTH   captured result (0 on error)
//  res_err    out  1            1 = reserved function or timeout
// BEHAVIOUR
//  Reset: FIFO empty, FSM IDLE, cmd_ready=1, unit_en=0, unit_fun=0, unit_in1/in2=0, res_valid=0, res_data=0, res_err=0.
//  FIFO: registered wr/rd pointers with an extra wrap bit. full = ptr MSBs differ & rest equal.
//   Simultaneous push and pop when full is illegal: cmd_ready=0 blocks the push. Push and pop in one cycle when non-empty are both performed.
//  Decode: [3:2] 00 arith, 01 logic, 10 cmp, 11 shift. cmd_fun 4'b1110/4'b1111 are reserved.
//  FSM:
//   IDLE  : FIFO non-empty -> pop head into operand regs.
//           If reserved: go DONE with res_err=1, res_data=0, no enable.
//           Otherwise go ISSUE.
//   ISSUE : unit_en = one-hot of the unit, unit_fun / unit_in1 / unit_in2 driven from registers. Lasts exactly 1 cycle, then WAIT.
//   WAIT  : unit_en=0; unit_in*/unit_fun keep their values. Timeout counter counts up from 0.
//           Selected unit_flag=1 -> latch its unit_out slice into res_data, res_err=0, go DONE.
//           Counter reaches TIMEOUT-1 with no flag -> res_data=0, res_err=1, go DONE.
//           Flags of unselected units are ignored.
//   DONE  : res_valid=1; res_data/res_err stable until res_ready.
//           On handshake: res_valid drops next cycle. Go IDLE, or straight into pop+ISSUE if the FIFO is non-empty (back-to-back).
//  Latency (unit flags 1 cycle after enable, FIFO empty, res_ready=1):
//   push at cycle 0 -> ISSUE 1 -> flag seen 2 -> res_valid 3.
//  Reset mid-operation: all state, FIFO contents and pending result discarded immediately; unit_en forced 0.
//  Ordering: results are returned strictly in command order, one command in flight.
// STRUCTURE
//  Shared package alu_pkg: unit-select encodings (ALU_ARITH=2'b00, ALU_LOGIC, ALU_CMP, ALU_SHIFT), SHIFT_SHR=2'b00, SHIFT_SHL=2'b01, reserved codes, FSM state encodings.
//  Sub-module alu_cmd_fifo (parameterised DATA_WIDTH*2+4 wide, FIFO_DEPTH deep, with push/pop/full/empty).
//  FSM and decode live in this module.
// TESTING
//  1 Shift SHR: cmd_fun=4'b1100, A=38, B=20; shift unit model flags after 1 cycle -> unit_en=4'b1000 for 1 cycle, unit_fun=00; res_data=19, res_err=0.
//  2 Shift SHL: cmd_fun=4'b1101, A=38 -> unit_fun=01, res_data=76, res_err=0; latency push->res_valid = 3 cycles.
//  3 Reserved: cmd_fun=4'b1111 -> unit_en stays 0, res_valid with res_err=1, res_data=0.
//  4 Timeout: arith model never flags, cmd_fun=4'b0000 -> res_err=1 exactly TIMEOUT cycles after WAIT entry.
//  5 Backpressure: push 5 cmds with res_ready=0 -> cmd_ready=0 after 4 buffered (+1 in flight).
//    Release res_ready -> 5 results in order, unit_en never two bits hot.
//  6 Reset mid-WAIT: assert rst while in WAIT -> next edge-free sample shows res_valid=0, unit_en=0, cmd_ready=1; queued commands are never issued.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command path: unit selects, function codes, FSM states.
package alu_pkg;

  localparam int unsigned NUM_UNITS = 4;
  localparam int unsigned FUN_W     = 4;

  typedef enum logic [1:0] {
    ALU_ARITH = 2'b00,
    ALU_LOGIC = 2'b01,
    ALU_CMP   = 2'b10,
    ALU_SHIFT = 2'b11
  } alu_unit_e;

  localparam logic [1:0] SHIFT_SHR = 2'b00;
  localparam logic [1:0] SHIFT_SHL = 2'b01;

  localparam logic [FUN_W-1:0] FUN_RSV0 = 4'b1110;
  localparam logic [FUN_W-1:0] FUN_RSV1 = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic is_reserved(input logic [FUN_W-1:0] fun);
    return (fun == FUN_RSV0) || (fun == FUN_RSV1);
  endfunction

  function automatic logic [NUM_UNITS-1:0] unit_onehot(input alu_unit_e unit);
    return NUM_UNITS'(1) << unit;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: flop array with wrap-bit read/write pointers.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// Buffers ALU commands, issues each to one execution unit for a single cycle,
// and returns the unit's result (or an error) through a valid/ready port.
module alu_cmd_dispatcher
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [FUN_W-1:0]                  cmd_fun,
  input  logic [DATA_WIDTH-1:0]             cmd_a,
  input  logic [DATA_WIDTH-1:0]             cmd_b,
  output logic [DATA_WIDTH-1:0]             unit_in1,
  output logic [DATA_WIDTH-1:0]             unit_in2,
  output logic [1:0]                        unit_fun,
  output logic [NUM_UNITS-1:0]              unit_en,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]   unit_out,
  input  logic [NUM_UNITS-1:0]              unit_flag,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [DATA_WIDTH-1:0]             res_data,
  output logic                              res_err
);

  localparam int unsigned FW    = 2*DATA_WIDTH + FUN_W;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  logic [FW-1:0]         head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  take;
  logic [FUN_W-1:0]      head_fun;
  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic [DATA_WIDTH-1:0] sel_out;

  state_e                state_q, state_d;
  alu_unit_e             sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_UNITS-1:0]  unit_en_q, unit_en_d;
  logic [1:0]            unit_fun_q, unit_fun_d;
  logic [DATA_WIDTH-1:0] in1_q, in1_d;
  logic [DATA_WIDTH-1:0] in2_q, in2_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;

  alu_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid & cmd_ready),
    .din   ({cmd_fun, cmd_a, cmd_b}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready                 = ~fifo_full;
  assign {head_fun, head_a, head_b} = head;
  assign sel_out                   = unit_out[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

  assign unit_en   = unit_en_q;
  assign unit_fun  = unit_fun_q;
  assign unit_in1  = in1_q;
  assign unit_in2  = in2_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

  // Next-state and output decode; 'take' pops the FIFO head from IDLE or right after a DONE handshake.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    unit_en_d   = '0;
    unit_fun_d  = unit_fun_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    pop         = 1'b0;
    take        = 1'b0;

    case (state_q)
      ST_IDLE: take = ~fifo_empty;
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (unit_flag[sel_q]) begin
          res_data_d  = sel_out;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
          take        = ~fifo_empty;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      pop        = 1'b1;
      in1_d      = head_a;
      in2_d      = head_b;
      unit_fun_d = head_fun[1:0];
      sel_d      = alu_unit_e'(head_fun[3:2]);
      if (is_reserved(head_fun)) begin
        res_data_d  = '0;
        res_err_d   = 1'b1;
        res_valid_d = 1'b1;
        state_d     = ST_DONE;
      end else begin
        unit_en_d = unit_onehot(alu_unit_e'(head_fun[3:2]));
        state_d   = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= ALU_ARITH;
      cnt_q       <= '0;
      unit_en_q   <= '0;
      unit_fun_q  <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      unit_en_q   <= unit_en_d;
      unit_fun_q  <= unit_fun_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule
